serial_deframer: RTL and testbench

Downstream consumer for the serial bit stream produced by the serial-in/serial-out shift-register stage. It hunts the LSB-first stream for a sync word and then assembles a fixed number of WIDTH-bit payload words. It presents each word on a registered parallel output with a valid/ready handshake and returns to hunting after every frame.

---
 rtl/serial_deframer.sv | 141 ++++++++++++++
 tb/tb_serial_deframer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_deframer.sv
// serial_deframer: hunts an LSB-first serial stream for a sync word, then
// assembles FRAME_WORDS payload words of WIDTH bits and offers each one on a
// registered valid/ready output. Returns to hunting after every frame.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_HUNT | sliding the sync window over accepted bits, waiting for SYNC
// ST_LOCK | collecting payload bits into words until the frame is complete
module serial_deframer #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] SYNC        = 8'hA5,
  parameter int               FRAME_WORDS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             si,
  input  logic             si_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             locked,
  output logic             overrun
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam int BW = $clog2(WIDTH);
  localparam int CW = $clog2(FRAME_WORDS + 1);

  localparam logic [FW-1:0] FILL_FULL = FW'(WIDTH);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [CW-1:0] WORD_LAST = CW'(FRAME_WORDS - 1);

  typedef enum logic [0:0] {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] window;
  logic [WIDTH-1:0] window_shift;
  logic [FW-1:0]    fill_cnt;
  logic [FW-1:0]    fill_inc;
  logic [WIDTH-1:0] asm_q;
  logic [WIDTH-1:0] asm_shift;
  logic [BW-1:0]    bit_cnt;
  logic [CW-1:0]    word_cnt;
  logic             sync_hit;
  logic             word_done;
  logic             frame_done;

  // Both shift paths insert the new bit at the MSB, so after WIDTH shifts the
  // first received bit lands in bit 0.
  assign window_shift = {si, window[WIDTH-1:1]};
  assign asm_shift    = {si, asm_q[WIDTH-1:1]};

  // Fill count saturates; a match needs a window made entirely of real bits
  // (counting the one arriving now), so reset zeros can never match.
  assign fill_inc   = (fill_cnt == FILL_FULL) ? fill_cnt : fill_cnt + 1'b1;
  assign sync_hit   = (state == ST_HUNT) && si_valid &&
                      (fill_inc == FILL_FULL) && (window_shift == SYNC);
  assign word_done  = (state == ST_LOCK) && si_valid && (bit_cnt == BIT_LAST);
  assign frame_done = word_done && (word_cnt == WORD_LAST);

  assign locked = (state == ST_LOCK);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: lock on sync, release on the last bit of the frame.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_HUNT: if (sync_hit)   state_nxt = ST_LOCK;
      ST_LOCK: if (frame_done) state_nxt = ST_HUNT;
      default: state_nxt = ST_HUNT;
    endcase
  end

  // Sync window, fill count, payload assembly and bit/word counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window   <= '0;
      fill_cnt <= '0;
      asm_q    <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
    end else if (si_valid) begin
      if (state == ST_HUNT) begin
        window   <= window_shift;
        fill_cnt <= fill_inc;
        if (sync_hit) begin
          bit_cnt  <= '0;
          word_cnt <= '0;
        end
      end else begin
        asm_q <= asm_shift;
        if (word_done) begin
          bit_cnt  <= '0;
          word_cnt <= word_cnt + 1'b1;
          if (frame_done) begin
            // Next frame hunts from an empty window, never from payload bits.
            window   <= '0;
            fill_cnt <= '0;
          end
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  // Output holding register with valid/ready handshake and overrun pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (word_done) begin
        if (!dout_valid || dout_ready) begin
          dout       <= asm_shift;
          dout_valid <= 1'b1;
        end else begin
          // Held word wins; the new one is dropped but framing continues.
          overrun <= 1'b1;
        end
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_deframer.sv
// Self-checking bench for serial_deframer: directed frames plus randomized
// streams, compared against a bit-queue reference model through a scoreboard.
module tb_serial_deframer;

  localparam int               WIDTH       = 8;
  localparam logic [WIDTH-1:0] SYNC        = 8'hA5;
  localparam int               FRAME_WORDS = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             si;
  logic             si_valid;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             locked;
  logic             overrun;

  serial_deframer #(
    .WIDTH(WIDTH),
    .SYNC(SYNC),
    .FRAME_WORDS(FRAME_WORDS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .si(si),
    .si_valid(si_valid),
    .dout(dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .locked(locked),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: recent hunt bits, payload bits of the current
  // word, expected words in order, and the expected flag outputs.
  bit               hunt_q[$];
  bit               pay_q[$];
  logic [WIDTH-1:0] exp_q[$];
  bit               m_locked  = 1'b0;
  bit               m_valid   = 1'b0;
  bit               m_overrun = 1'b0;
  int               m_words   = 0;

  task automatic check(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hunt_q.delete();
    pay_q.delete();
    exp_q.delete();
    m_locked  = 1'b0;
    m_valid   = 1'b0;
    m_overrun = 1'b0;
    m_words   = 0;
  endtask

  // One clock edge of the reference behaviour, given the inputs at that edge.
  task automatic model_edge(input bit b, input bit v, input bit r);
    bit               done;
    logic [WIDTH-1:0] w;
    done      = 1'b0;
    w         = '0;
    m_overrun = 1'b0;
    if (v) begin
      if (!m_locked) begin
        hunt_q.push_back(b);
        if (hunt_q.size() > WIDTH) void'(hunt_q.pop_front());
        if (hunt_q.size() == WIDTH) begin
          for (int i = 0; i < WIDTH; i++) w[i] = hunt_q[i];
          if (w == SYNC) begin
            m_locked = 1'b1;
            m_words  = 0;
            pay_q.delete();
          end
        end
      end else begin
        pay_q.push_back(b);
        if (pay_q.size() == WIDTH) begin
          for (int i = 0; i < WIDTH; i++) w[i] = pay_q[i];
          pay_q.delete();
          done = 1'b1;
          m_words++;
          if (m_words == FRAME_WORDS) begin
            m_locked = 1'b0;
            hunt_q.delete();
          end
        end
      end
    end
    if (done) begin
      if (!m_valid || r) begin
        exp_q.push_back(w);
        m_valid = 1'b1;
      end else begin
        m_overrun = 1'b1;
      end
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model.
  task automatic step(input bit b, input bit v, input bit r);
    si         = b;
    si_valid   = v;
    dout_ready = r;
    @(posedge clk);
    model_edge(b, v, r);
    #1;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input bit r, input bit gapped);
    for (int i = 0; i < WIDTH; i++) begin
      if (gapped) step(1'($urandom_range(0, 1)), 1'b0, r);
      step(w[i], 1'b1, r);
    end
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1,
                            input bit r, input bit gapped);
    send_word(SYNC, r, gapped);
    send_word(w0, r, gapped);
    send_word(w1, r, gapped);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b1);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic reset_pulse();
    rst_n = 1'b0;
    #2;
    check("rst_locked", WIDTH'(locked), '0);
    check("rst_dout_valid", WIDTH'(dout_valid), '0);
    check("rst_dout", dout, '0);
    check("rst_overrun", WIDTH'(overrun), '0);
    model_reset();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compares flags every cycle and pops the scoreboard whenever the
  // DUT presents a new word.
  bit prev_valid = 1'b0;
  bit prev_ready = 1'b0;
  always @(negedge clk) begin
    logic [WIDTH-1:0] w;
    check("locked", WIDTH'(locked), WIDTH'(m_locked));
    check("dout_valid", WIDTH'(dout_valid), WIDTH'(m_valid));
    check("overrun", WIDTH'(overrun), WIDTH'(m_overrun));
    if (dout_valid === 1'b1 && (!prev_valid || prev_ready)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %h expected none at %0t", dout, $time);
      end else begin
        w = exp_q.pop_front();
        check("dout", dout, w);
      end
    end
    prev_valid = (dout_valid === 1'b1);
    prev_ready = (dout_ready === 1'b1);
  end

  initial begin
    rst_n      = 1'b0;
    si         = 1'b0;
    si_valid   = 1'b0;
    dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("init_dout", dout, '0);
    check("init_dout_valid", WIDTH'(dout_valid), '0);
    check("init_locked", WIDTH'(locked), '0);
    check("init_overrun", WIDTH'(overrun), '0);
    rst_n = 1'b1;
    idle(2);

    // Basic frame, consumer always ready.
    send_frame(8'h3C, 8'hC3, 1'b1, 1'b0);
    idle(3);

    // Junk prefix before the sync.
    for (int i = 0; i < 5; i++) begin
      logic [4:0] junk;
      junk = 5'b10110;
      step(junk[i], 1'b1, 1'b1);
    end
    send_frame(8'h3C, 8'hC3, 1'b1, 1'b0);
    idle(3);

    // Partial sync (7 bits) right after reset must not lock.
    reset_pulse();
    for (int i = 0; i < WIDTH - 1; i++) step(SYNC[i], 1'b1, 1'b1);
    idle(4);
    check("partial_sync_no_lock", WIDTH'(locked), '0);
    reset_pulse();

    // Gapped input.
    send_frame(8'h3C, 8'hC3, 1'b1, 1'b1);
    idle(3);

    // Backpressure for the whole frame, then release.
    send_frame(8'h3C, 8'hC3, 1'b0, 1'b0);
    check("bp_held_dout", dout, 8'h3C);
    step(1'b0, 1'b0, 1'b0);
    idle(3);

    // Ready asserted exactly on the edge where word 2 completes.
    send_word(SYNC, 1'b0, 1'b0);
    send_word(8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < WIDTH; i++) begin
      logic [WIDTH-1:0] w2;
      w2 = 8'hC3;
      step(w2[i], 1'b1, (i == WIDTH - 1));
    end
    step(1'b0, 1'b0, 1'b0);
    check("simul_dout", dout, 8'hC3);
    idle(3);

    // Reset four bits into the payload, then a fresh frame.
    send_word(SYNC, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b1);
    reset_pulse();
    send_frame(8'h3C, 8'hC3, 1'b1, 1'b0);
    idle(3);

    // Randomized streams: junk, frames, sporadic valid and ready.
    for (int f = 0; f < 150; f++) begin
      int               njunk;
      logic [WIDTH-1:0] wa;
      logic [WIDTH-1:0] wb;
      njunk = $urandom_range(0, 10);
      for (int j = 0; j < njunk; j++)
        step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      wa = WIDTH'($urandom);
      wb = WIDTH'($urandom);
      for (int k = 0; k < 3 * WIDTH; k++) begin
        logic [3*WIDTH-1:0] bits;
        bits = {wb, wa, SYNC};
        while ($urandom_range(0, 3) == 0)
          step(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
        step(bits[k], 1'b1, ($urandom_range(0, 2) != 0));
      end
    end
    idle(6);

    check("leftover_words", WIDTH'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
